// File: rtl/dbus_periph_bridge.sv
// Data-bus bridge between the core's data-memory port, the external data RAM
// and a small peripheral block (GPIO, 64-bit cycle timer, UART TX with FIFO).
// Reads return combinationally so the core's MEM stage timing is unchanged.
//
// Bus handshake: ram_ce_i is a single-cycle access strobe with no ready/stall
// path. An access is presented for one cycle, writes take effect at the
// following rising edge, and read data is valid in that same cycle. There is
// no back-pressure; a push into a full UART FIFO is dropped and flagged.
module dbus_periph_bridge #(
    parameter logic [3:0] PERIPH_HI  = 4'h1,
    parameter int         CLK_DIV    = 434,
    parameter int         FIFO_DEPTH = 4,
    parameter int         GPIO_W     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ram_addr_i,
    input  logic [31:0]       ram_data_i,
    input  logic              ram_we_i,
    input  logic [3:0]        ram_sel_i,
    input  logic              ram_ce_i,
    output logic [31:0]       ram_data_o,
    output logic [31:0]       dram_addr_o,
    output logic [31:0]       dram_data_o,
    output logic              dram_we_o,
    output logic [3:0]        dram_sel_o,
    output logic              dram_ce_o,
    input  logic [31:0]       dram_data_i,
    output logic [GPIO_W-1:0] gpio_o,
    output logic              uart_tx_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [7:0] OFF_GPIO = 8'h00;
    localparam logic [7:0] OFF_UTX  = 8'h04;
    localparam logic [7:0] OFF_STAT = 8'h08;
    localparam logic [7:0] OFF_TLO  = 8'h0C;
    localparam logic [7:0] OFF_THI  = 8'h10;

    logic              periph_hit;
    logic              periph_wr;
    logic              periph_rd;
    logic [7:0]        offset;
    logic [31:0]       periph_rdata;

    logic [GPIO_W-1:0] gpio_q;
    logic [63:0]       timer_q;
    logic [31:0]       shadow_q;

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              ovf_q;

    logic [1:0]        state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;

    logic              fifo_empty;
    logic              fifo_full;
    logic              baud_done;
    logic              push_req;
    logic              push_ok;
    logic              pop;
    logic              busy;

    // Address decode and RAM passthrough
    assign periph_hit  = ram_ce_i & (ram_addr_i[31:28] == PERIPH_HI);
    assign dram_ce_o   = ram_ce_i & ~periph_hit & ~rst;
    assign dram_we_o   = ram_we_i & dram_ce_o;
    assign dram_addr_o = ram_addr_i;
    assign dram_data_o = ram_data_i;
    assign dram_sel_o  = ram_sel_i;

    assign offset    = ram_addr_i[7:0];
    assign periph_wr = periph_hit & ram_we_i;
    assign periph_rd = periph_hit & ~ram_we_i;

    // FIFO / UART control terms; a pop frees a slot for a same-edge push
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign baud_done  = (baud_q == BAUD_LAST);
    assign busy       = (state_q != ST_IDLE);
    assign push_req   = periph_wr & (offset == OFF_UTX) & ram_sel_i[0];
    assign pop        = ~fifo_empty &
                        ((state_q == ST_IDLE) | ((state_q == ST_STOP) & baud_done));
    assign push_ok    = push_req & (~fifo_full | pop);

    // Peripheral register read mux
    always_comb begin
        periph_rdata = '0;
        case (offset)
            OFF_GPIO: periph_rdata = 32'(gpio_q);
            OFF_STAT: periph_rdata = {28'd0, ovf_q, busy, fifo_empty, fifo_full};
            OFF_TLO:  periph_rdata = timer_q[31:0];
            OFF_THI:  periph_rdata = shadow_q;
            default:  periph_rdata = '0;
        endcase
    end

    // Core read data: RAM, peripheral, or zero (also zero during reset)
    always_comb begin
        ram_data_o = '0;
        if (!rst) begin
            if (dram_ce_o)
                ram_data_o = dram_data_i;
            else if (periph_rd)
                ram_data_o = periph_rdata;
        end
    end

    // GPIO register, low byte lane only
    always_ff @(posedge clk) begin
        if (rst)
            gpio_q <= '0;
        else if (periph_wr && offset == OFF_GPIO && ram_sel_i[0])
            gpio_q <= ram_data_i[GPIO_W-1:0];
    end

    assign gpio_o = gpio_q;

    // Free-running timer; a TIMER_LO read snapshots the high word for TIMER_HI
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q  <= '0;
            shadow_q <= '0;
        end else begin
            if (periph_wr && offset == OFF_TLO)
                timer_q <= '0;
            else
                timer_q <= timer_q + 64'd1;
            if (periph_rd && offset == OFF_TLO)
                shadow_q <= timer_q[63:32];
        end
    end

    // FIFO storage (pointers carry the reset, the array does not need one)
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_q] <= ram_data_i[7:0];
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (pop && !push_ok)
                count_q <= count_q - CNT_W'(1);
            if (periph_wr && offset == OFF_STAT)
                ovf_q <= 1'b0;
            else if (push_req && !push_ok)
                ovf_q <= 1'b1;
        end
    end

    // UART 8N1 transmitter FSM; baud counter restarts on every state change
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= fifo_mem[rd_ptr_q];
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7)
                            state_q <= ST_STOP;
                        else
                            bit_q <= bit_q + 3'd1;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= fifo_mem[rd_ptr_q];
                            state_q <= ST_START;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
            endcase
        end
    end

    // Serial line level follows the current FSM state
    always_comb begin
        uart_tx_o = 1'b1;
        case (state_q)
            ST_START: uart_tx_o = 1'b0;
            ST_DATA:  uart_tx_o = shift_q[0];
            default:  uart_tx_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_dbus_periph_bridge.sv
// Directed bench for dbus_periph_bridge with CLK_DIV=4, FIFO_DEPTH=4.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dbus_periph_bridge;

    localparam logic [31:0] A_GPIO = 32'h1000_0000;
    localparam logic [31:0] A_UTX  = 32'h1000_0004;
    localparam logic [31:0] A_STAT = 32'h1000_0008;
    localparam logic [31:0] A_TLO  = 32'h1000_000C;
    localparam logic [31:0] A_THI  = 32'h1000_0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_addr_i;
    logic [31:0] ram_data_i;
    logic        ram_we_i;
    logic [3:0]  ram_sel_i;
    logic        ram_ce_i;
    logic [31:0] ram_data_o;
    logic [31:0] dram_addr_o;
    logic [31:0] dram_data_o;
    logic        dram_we_o;
    logic [3:0]  dram_sel_o;
    logic        dram_ce_o;
    logic [31:0] dram_data_i;
    logic [5:0]  gpio_o;
    logic        uart_tx_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dbus_periph_bridge #(
        .PERIPH_HI (4'h1),
        .CLK_DIV   (4),
        .FIFO_DEPTH(4),
        .GPIO_W    (6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ram_addr_i (ram_addr_i),
        .ram_data_i (ram_data_i),
        .ram_we_i   (ram_we_i),
        .ram_sel_i  (ram_sel_i),
        .ram_ce_i   (ram_ce_i),
        .ram_data_o (ram_data_o),
        .dram_addr_o(dram_addr_o),
        .dram_data_o(dram_data_o),
        .dram_we_o  (dram_we_o),
        .dram_sel_o (dram_sel_o),
        .dram_ce_o  (dram_ce_o),
        .dram_data_i(dram_data_i),
        .gpio_o     (gpio_o),
        .uart_tx_o  (uart_tx_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_bus(input logic ce, input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel);
        ram_ce_i   = ce;
        ram_we_i   = we;
        ram_addr_i = addr;
        ram_data_i = data;
        ram_sel_i  = sel;
    endtask

    task automatic bus_idle();
        set_bus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // One write cycle; returns on the falling edge after the write edge
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
        set_bus(1'b1, 1'b1, addr, data, sel);
        tick();
        bus_idle();
    endtask

    // Combinational read that is withdrawn before the next rising edge
    task automatic peek(input logic [31:0] addr, output logic [31:0] data);
        set_bus(1'b1, 1'b0, addr, 32'h0, 4'hF);
        #1;
        data = ram_data_o;
        bus_idle();
    endtask

    initial begin
        logic [31:0] rd;
        logic [9:0]  frame;
        logic        rx [0:199];
        int          busy_cycles;
        int          low_cycles;

        rst = 1'b1;
        bus_idle();
        dram_data_i = 32'hCAFE_F00D;

        // ---------------- reset ----------------
        @(negedge clk);
        set_bus(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("rst_dram_ce", dram_ce_o, 1'b0);
        chk("rst_dram_we", dram_we_o, 1'b0);
        chk("rst_rdata", ram_data_o, 32'h0);
        bus_idle();
        tick();
        tick();
        chk("rst_gpio", gpio_o, 6'h0);
        chk("rst_tx", uart_tx_o, 1'b1);
        rst = 1'b0;
        tick();
        peek(A_STAT, rd);
        chk("rst_stat", rd, 32'h2);

        // ---------------- RAM passthrough ----------------
        set_bus(1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("ram_wr_ce", dram_ce_o, 1'b1);
        chk("ram_wr_we", dram_we_o, 1'b1);
        chk("ram_wr_addr", dram_addr_o, 32'h0000_0040);
        chk("ram_wr_data", dram_data_o, 32'hDEAD_BEEF);
        chk("ram_wr_sel", dram_sel_o, 4'hF);
        dram_data_i = 32'h1234_5678;
        peek(32'h0000_0040, rd);
        chk("ram_rd_data", rd, 32'h1234_5678);
        set_bus(1'b1, 1'b0, 32'h2000_0000, 32'h0, 4'hF);
        #1;
        chk("ram_other_hi_ce", dram_ce_o, 1'b1);
        set_bus(1'b1, 1'b0, A_GPIO, 32'h0, 4'hF);
        #1;
        chk("periph_dram_ce", dram_ce_o, 1'b0);
        chk("periph_rd_gpio0", ram_data_o, 32'h0);
        set_bus(1'b0, 1'b1, 32'h0000_0040, 32'h1, 4'hF);
        #1;
        chk("idle_dram_we", dram_we_o, 1'b0);
        chk("idle_rdata", ram_data_o, 32'h0);
        bus_idle();

        // ---------------- GPIO ----------------
        wr(A_GPIO, 32'h0000_002A, 4'h1);
        chk("gpio_wr", gpio_o, 6'h2A);
        peek(A_GPIO, rd);
        chk("gpio_rd", rd, 32'h0000_002A);
        wr(A_GPIO, 32'h0000_0015, 4'h2);
        chk("gpio_sel1_ignored", gpio_o, 6'h2A);
        wr(32'h1000_0014, 32'h0000_0015, 4'h1);
        chk("gpio_unmapped_wr", gpio_o, 6'h2A);
        peek(32'h1000_0014, rd);
        chk("unmapped_rd", rd, 32'h0);
        wr(A_GPIO, 32'hFFFF_FF15, 4'h1);
        chk("gpio_trunc", gpio_o, 6'h15);
        peek(A_UTX, rd);
        chk("utx_rd_zero", rd, 32'h0);

        // ---------------- timer ----------------
        wr(A_TLO, 32'h0, 4'hF);
        set_bus(1'b1, 1'b0, A_TLO, 32'h0, 4'hF);
        #1;
        chk("timer_after_clear", ram_data_o, 32'h0);
        tick();
        #1;
        chk("timer_next_cycle", ram_data_o, 32'h1);
        bus_idle();
        tick();
        force dut.timer_q = 64'h0000_0005_FFFF_FFFF;
        set_bus(1'b1, 1'b0, A_TLO, 32'h0, 4'hF);
        #1;
        chk("timer_lo_near_wrap", ram_data_o, 32'hFFFF_FFFF);
        tick();
        release dut.timer_q;
        bus_idle();
        tick();
        tick();
        peek(A_THI, rd);
        chk("timer_hi_coherent", rd, 32'h5);

        // ---------------- single UART frame ----------------
        frame = {1'b1, 8'h55, 1'b0};
        wr(A_UTX, 32'h0000_0055, 4'h1);
        chk("frame_pre_tx", uart_tx_o, 1'b1);
        peek(A_STAT, rd);
        chk("frame_pre_stat", rd, 32'h0);
        tick();
        for (int k = 0; k < 40; k++) begin
            peek(A_STAT, rd);
            chk($sformatf("frame_tx_%0d", k), uart_tx_o, frame[k/4]);
            if (k == 20)
                chk("frame_mid_stat", rd, 32'h6);
            tick();
        end
        chk("frame_post_tx", uart_tx_o, 1'b1);
        peek(A_STAT, rd);
        chk("frame_post_stat", rd, 32'h2);

        // ---------------- FIFO fill / overflow ----------------
        for (int i = 0; i < 6; i++) begin
            set_bus(1'b1, 1'b1, A_UTX, 32'hA1 + i, 4'h1);
            tick();
        end
        bus_idle();
        peek(A_STAT, rd);
        chk("ovf_stat", rd, 32'hD);
        busy_cycles = 0;
        for (int j = 4; j < 200; j++) begin
            peek(A_STAT, rd);
            rx[j] = uart_tx_o;
            if (rd[2])
                busy_cycles++;
            tick();
        end
        chk("ovf_busy_cycles", busy_cycles, 196);
        for (int f = 0; f < 5; f++) begin
            logic [8:0] got;
            for (int b = 0; b < 9; b++)
                got[b] = rx[f*40 + 4*(b+1) + 2];
            chk($sformatf("ovf_frame%0d", f), got, {1'b1, 8'hA1 + 8'(f)});
            if (f > 0)
                chk($sformatf("ovf_start%0d", f), rx[f*40 + 2], 1'b0);
        end
        peek(A_STAT, rd);
        chk("ovf_done_stat", rd, 32'hA);
        wr(A_STAT, 32'h0, 4'hF);
        peek(A_STAT, rd);
        chk("ovf_cleared", rd, 32'h2);

        // ---------------- push into full FIFO on a pop edge ----------------
        for (int i = 0; i < 5; i++) begin
            set_bus(1'b1, 1'b1, A_UTX, 32'hB1 + i, 4'h1);
            tick();
        end
        bus_idle();
        peek(A_STAT, rd);
        chk("full_stat", rd, 32'h5);
        for (int i = 0; i < 36; i++)
            tick();
        wr(A_UTX, 32'h0000_00B6, 4'h1);
        peek(A_STAT, rd);
        chk("full_push_on_pop", rd, 32'h5);
        wr(A_UTX, 32'h0000_00B7, 4'h1);
        peek(A_STAT, rd);
        chk("full_push_drop", rd, 32'hD);

        // ---------------- reset mid-frame ----------------
        for (int i = 0; i < 4; i++)
            tick();
        chk("pre_rst_gpio", gpio_o, 6'h15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_tx", uart_tx_o, 1'b1);
        chk("midrst_gpio", gpio_o, 6'h0);
        peek(A_STAT, rd);
        chk("midrst_stat", rd, 32'h2);
        peek(A_TLO, rd);
        chk("midrst_timer", rd, 32'h0);
        low_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (uart_tx_o !== 1'b1)
                low_cycles++;
        end
        chk("midrst_no_frame", low_cycles, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
